// File: rtl/lcd_update_scheduler_if.sv
// Keyboard-side and display-side signals of the LCD update scheduler.
// The master modport is the scheduler; the slave modport is the keyboard decoder plus the display controller.
interface lcd_update_scheduler_if #(
    parameter int NCHARS = 11
);
    // New is a one-cycle valid strobe with no ready: Char is consumed in the cycle New=1.
    // Change is a one-cycle valid strobe; the display acknowledges by raising ShowBusy
    // some cycles later and lowering it when the redraw is complete.
    logic                  New;
    logic [6:0]            Char;
    logic                  ShowBusy;
    logic [7*NCHARS-1:0]   String;
    logic                  Change;
    logic                  CompleteOut;
    logic [3:0]            Length;
    logic                  Overflow;
    logic [1:0]            StateDbg;

    modport master (
        input  New, Char, ShowBusy,
        output String, Change, CompleteOut, Length, Overflow, StateDbg
    );

    modport slave (
        output New, Char, ShowBusy,
        input  String, Change, CompleteOut, Length, Overflow, StateDbg
    );
endinterface

// File: rtl/lcd_update_scheduler.sv
// Editable line buffer for keyboard input plus a scheduler that publishes snapshots
// to the LCD controller only when it is idle, coalescing edits made while it is busy.
module lcd_update_scheduler #(
    parameter int NCHARS         = 11,
    parameter int ACK_TIMEOUT    = 16,
    parameter int REFRESH_CYCLES = 1000000
) (
    input  logic                  Clock,
    input  logic                  Reset,
    lcd_update_scheduler_if.master bus
);
    localparam int SW = 7 * NCHARS;
    localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_BUSY     = 2'd2
    } state_t;

    logic [6:0]    line_q [NCHARS];
    logic [6:0]    line_d [NCHARS];
    logic [3:0]    len_q, len_d;
    logic          complete_q, complete_d;
    logic          overflow_q, overflow_d;
    logic          dirty_q, dirty_d;
    logic          change_q, change_d;
    logic [SW-1:0] string_q, string_d;
    state_t        state_q, state_d;
    logic [AW-1:0] ack_q, ack_d;
    logic [RW-1:0] ref_q, ref_d;
    logic          edit;
    logic          is_print;

    assign is_print = (bus.Char >= 7'h20) && (bus.Char <= 7'h7E);

    // Line editing: only the working buffer changes here; the snapshot is taken on issue.
    always_comb begin
        for (int i = 0; i < NCHARS; i++) line_d[i] = line_q[i];
        len_d      = len_q;
        complete_d = complete_q;
        overflow_d = overflow_q;
        edit       = 1'b0;
        if (bus.New) begin
            if (bus.Char == 7'h1B) begin
                for (int i = 0; i < NCHARS; i++) line_d[i] = 7'h20;
                len_d      = 4'd0;
                complete_d = 1'b0;
                overflow_d = 1'b0;
                edit       = 1'b1;
            end else if (!complete_q) begin
                if (is_print) begin
                    if (len_q < 4'(NCHARS)) begin
                        for (int i = 0; i < NCHARS; i++)
                            if (4'(i) == len_q) line_d[i] = bus.Char;
                        len_d = len_q + 4'd1;
                        edit  = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else if (bus.Char == 7'h08) begin
                    if (len_q != 4'd0) begin
                        for (int i = 0; i < NCHARS; i++)
                            if (4'(i) == len_q - 4'd1) line_d[i] = 7'h20;
                        len_d = len_q - 4'd1;
                        edit  = 1'b1;
                    end
                end else if (bus.Char == 7'h0D) begin
                    complete_d = 1'b1;
                    edit       = 1'b1;
                end
            end
        end
    end

    // Scheduler: a lost ack re-marks the line dirty so the update is retried.
    always_comb begin
        state_d  = state_q;
        string_d = string_q;
        change_d = 1'b0;
        dirty_d  = dirty_q;
        ack_d    = ack_q;
        ref_d    = ref_q;
        case (state_q)
            S_IDLE: begin
                if (dirty_q && !bus.ShowBusy) begin
                    for (int i = 0; i < NCHARS; i++) string_d[7*i +: 7] = line_q[i];
                    change_d = 1'b1;
                    dirty_d  = 1'b0;
                    ack_d    = '0;
                    ref_d    = '0;
                    state_d  = S_WAIT_ACK;
                end else if (!dirty_q && (REFRESH_CYCLES > 0)) begin
                    if (ref_q == RW'(REFRESH_CYCLES - 1)) begin
                        dirty_d = 1'b1;
                        ref_d   = '0;
                    end else begin
                        ref_d = ref_q + RW'(1);
                    end
                end
            end
            S_WAIT_ACK: begin
                if (bus.ShowBusy) begin
                    state_d = S_BUSY;
                end else if (ack_q == AW'(ACK_TIMEOUT - 1)) begin
                    dirty_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    ack_d = ack_q + AW'(1);
                end
            end
            S_BUSY: begin
                if (!bus.ShowBusy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (edit) dirty_d = 1'b1;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < NCHARS; i++) line_q[i] <= 7'h20;
            len_q      <= 4'd0;
            complete_q <= 1'b0;
            overflow_q <= 1'b0;
            dirty_q    <= 1'b0;
            change_q   <= 1'b0;
            string_q   <= {NCHARS{7'h20}};
            state_q    <= S_IDLE;
            ack_q      <= '0;
            ref_q      <= '0;
        end else begin
            for (int i = 0; i < NCHARS; i++) line_q[i] <= line_d[i];
            len_q      <= len_d;
            complete_q <= complete_d;
            overflow_q <= overflow_d;
            dirty_q    <= dirty_d;
            change_q   <= change_d;
            string_q   <= string_d;
            state_q    <= state_d;
            ack_q      <= ack_d;
            ref_q      <= ref_d;
        end
    end

    assign bus.String      = string_q;
    assign bus.Change      = change_q;
    assign bus.CompleteOut = complete_q;
    assign bus.Length      = len_q;
    assign bus.Overflow    = overflow_q;
    assign bus.StateDbg    = state_q;
endmodule

// File: tb/tb_lcd_update_scheduler.sv
// Bench for lcd_update_scheduler: directed edit sequences plus random typing against
// a queue-based line model and a reactive display model.
module tb_lcd_update_scheduler;
    localparam int NCHARS         = 11;
    localparam int ACK_TIMEOUT    = 16;
    localparam int REFRESH_CYCLES = 100;
    localparam int SW             = 7 * NCHARS;

    // ---------------- clock / reset ----------------
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    lcd_update_scheduler_if #(.NCHARS(NCHARS)) bus ();

    lcd_update_scheduler #(
        .NCHARS(NCHARS),
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus(bus)
    );

    // ---------------- scoreboard ----------------
    int vec_cnt = 0;
    int err_cnt = 0;
    logic [SW-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0]    m_line[$];
    bit            m_complete, m_overflow, m_pending, m_change;
    int            m_phase;   // 0 display free, 1 waiting for ack, 2 display drawing
    int            m_ack_cnt, m_ref_cnt;
    logic [SW-1:0] m_string;

    function automatic logic [SW-1:0] pack_line();
        logic [SW-1:0] p;
        for (int i = 0; i < NCHARS; i++)
            p[7*i +: 7] = (i < m_line.size()) ? m_line[i] : 7'h20;
        return p;
    endfunction

    task automatic model_reset();
        m_line.delete();
        m_complete = 0; m_overflow = 0; m_pending = 0; m_change = 0;
        m_phase = 0; m_ack_cnt = 0; m_ref_cnt = 0;
        m_string = {NCHARS{7'h20}};
        exp_q.delete();
    endtask

    task automatic model_edge(input bit nw, input logic [6:0] ch, input bit busy);
        logic [SW-1:0] snap;
        bit edit;
        snap = pack_line();
        edit = 0;
        m_change = 0;
        if (nw) begin
            if (ch == 7'h1B) begin
                m_line.delete(); m_complete = 0; m_overflow = 0; edit = 1;
            end else if (!m_complete) begin
                if (ch >= 7'h20 && ch <= 7'h7E) begin
                    if (m_line.size() < NCHARS) begin m_line.push_back(ch); edit = 1; end
                    else m_overflow = 1;
                end else if (ch == 7'h08) begin
                    if (m_line.size() > 0) begin void'(m_line.pop_back()); edit = 1; end
                end else if (ch == 7'h0D) begin
                    m_complete = 1; edit = 1;
                end
            end
        end
        if (m_phase == 0) begin
            if (m_pending && !busy) begin
                m_string = snap; m_change = 1; m_pending = 0;
                m_phase = 1; m_ack_cnt = 0; m_ref_cnt = 0;
                exp_q.push_back(snap);
            end else if (!m_pending) begin
                m_ref_cnt++;
                if (m_ref_cnt == REFRESH_CYCLES) begin m_pending = 1; m_ref_cnt = 0; end
            end
        end else if (m_phase == 1) begin
            if (busy) m_phase = 2;
            else begin
                m_ack_cnt++;
                if (m_ack_cnt == ACK_TIMEOUT) begin m_pending = 1; m_phase = 0; end
            end
        end else begin
            if (!busy) m_phase = 0;
        end
        if (edit) m_pending = 1;
    endtask

    // ---------------- display model ----------------
    bit disp_en = 0;
    int disp_delay = 2, disp_len = 40, disp_cd = 0, disp_left = 0;

    function automatic bit disp_step();
        bit b;
        if (disp_cd > 0) begin
            disp_cd--;
            if (disp_cd == 0) disp_left = disp_len;
        end
        b = (disp_left > 0);
        if (b) disp_left--;
        return b;
    endfunction

    task automatic compare_all();
        check_eq("change",   80'(bus.Change),      80'(m_change));
        check_eq("length",   80'(bus.Length),      80'(m_line.size()));
        check_eq("complete", 80'(bus.CompleteOut), 80'(m_complete));
        check_eq("overflow", 80'(bus.Overflow),    80'(m_overflow));
        check_eq("string",   80'(bus.String),      80'(m_string));
        if (bus.Change) begin
            if (exp_q.size() == 0) check_eq("issue_queue_level", 80'(exp_q.size()), 80'(1));
            else check_eq("issued_string", 80'(bus.String), 80'(exp_q.pop_front()));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input bit nw, input logic [6:0] ch);
        bit busy;
        @(negedge Clock);
        Reset = 1'b0;
        busy = disp_step();
        bus.New = nw; bus.Char = ch; bus.ShowBusy = busy;
        @(posedge Clock);
        model_edge(nw, ch, busy);
        #1;
        compare_all();
        if (disp_en && bus.Change) disp_cd = disp_delay;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 7'h00);
    endtask

    task automatic type_str(input string s);
        for (int i = 0; i < s.len(); i++) cycle(1'b1, 7'(s[i]));
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1;
        bus.New = 1'b0; bus.Char = 7'h00; bus.ShowBusy = 1'b0;
        disp_cd = 0; disp_left = 0;
        @(posedge Clock);
        model_reset();
        #1;
        compare_all();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [6:0] ch;
        int r;
        bus.New = 1'b0; bus.Char = 7'h00; bus.ShowBusy = 1'b0;
        model_reset();

        // Two characters with no display acknowledging: issue then ack-timeout retry.
        do_reset();
        disp_en = 0;
        type_str("HI");
        idle(40);
        check_eq("hi_length", 80'(bus.Length), 80'(2));
        check_eq("hi_string", 80'(bus.String[13:0]), 80'({7'h49, 7'h48}));

        // Typing while the display is drawing coalesces into one follow-up Change.
        disp_en = 1; disp_delay = 2; disp_len = 40;
        do_reset();
        cycle(1'b1, 7'h1B);
        idle(5);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 7'($urandom_range(32, 126)));
            idle(2);
        end
        idle(80);
        check_eq("busy_len5", 80'(bus.Length), 80'(5));

        // Overflow: 'L' is dropped once eleven characters are present.
        cycle(1'b1, 7'h1B);
        type_str("ABCDEFGHIJKL");
        idle(100);
        check_eq("full_length", 80'(bus.Length), 80'(11));
        check_eq("full_overflow", 80'(bus.Overflow), 80'(1));
        check_eq("slot10", 80'(bus.String[76:70]), 80'(7'h4B));

        // Backspace down to empty, then one more on an empty line.
        cycle(1'b1, 7'h1B);
        type_str("AB");
        cycle(1'b1, 7'h08);
        cycle(1'b1, 7'h08);
        cycle(1'b1, 7'h08);
        idle(100);
        check_eq("bs_string", 80'(bus.String), 80'({NCHARS{7'h20}}));

        // Enter locks the line; escape clears it.
        type_str("OK");
        cycle(1'b1, 7'h0D);
        cycle(1'b1, 7'h58);
        check_eq("ok_complete", 80'(bus.CompleteOut), 80'(1));
        check_eq("ok_length", 80'(bus.Length), 80'(2));
        idle(60);
        cycle(1'b1, 7'h1B);
        idle(60);
        check_eq("esc_complete", 80'(bus.CompleteOut), 80'(0));

        // Random typing with varying display behaviour.
        for (int blk = 0; blk < 6; blk++) begin
            disp_en = ($urandom_range(0, 3) != 0);
            disp_delay = $urandom_range(1, 4);
            disp_len = $urandom_range(1, 12);
            for (int i = 0; i < 100; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    r = $urandom_range(0, 11);
                    if (r == 0) ch = 7'h08;
                    else if (r == 1) ch = 7'h0D;
                    else if (r == 2) ch = ($urandom_range(0, 3) == 0) ? 7'h1B : 7'h41;
                    else if (r == 3) ch = 7'($urandom_range(0, 127));
                    else ch = 7'($urandom_range(32, 126));
                    cycle(1'b1, ch);
                end else begin
                    cycle(1'b0, 7'($urandom_range(0, 127)));
                end
            end
            idle(60);
        end

        // Periodic refresh with no input.
        disp_en = 1; disp_delay = 1; disp_len = 3;
        idle(350);

        // Reset while waiting for the display to acknowledge.
        disp_en = 0;
        cycle(1'b1, 7'h5A);
        for (int i = 0; i < 50 && m_phase != 1; i++) idle(1);
        check_eq("pre_rst_phase", 80'(bus.StateDbg), 80'(2'd1));
        do_reset();
        check_eq("rst_length", 80'(bus.Length), 80'(0));
        idle(30);

        check_eq("exp_q_empty", 80'(exp_q.size()), 80'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
